// File: rtl/asteroid_game_sequencer_pkg.sv
// Shared definitions for the asteroid game round controller: state codes,
// counter strobe bundle and parameter defaults.
package asteroid_game_sequencer_pkg;

  localparam int SCORE_W_DEF   = 8;
  localparam int NUM_LIVES_DEF = 3;
  localparam int LIVES_W_DEF   = 2;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_WAIT_FRAME  = 4'd1,
    S_MOVE_AST    = 4'd2,
    S_WAIT_AST    = 4'd3,
    S_MOVE_ROCKET = 4'd4,
    S_WAIT_ROCKET = 4'd5,
    S_CHECK       = 4'd6,
    S_RESPAWN     = 4'd7,
    S_GAMEOVER    = 4'd8
  } state_e;

  typedef struct packed {
    logic clear;
    logic inc;
    logic dec;
  } cnt_ctl_t;

endpackage

// File: rtl/asteroid_game_sequencer_score_lives_counter.sv
// Saturating score counter and lives counter, driven by strobes from the
// round FSM. clear reloads both for a new game.
module asteroid_game_sequencer_score_lives_counter
  import asteroid_game_sequencer_pkg::*;
#(
  parameter int SCORE_W   = SCORE_W_DEF,
  parameter int NUM_LIVES = NUM_LIVES_DEF,
  parameter int LIVES_W   = LIVES_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  cnt_ctl_t           ctl,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives
);

  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(NUM_LIVES);

  always_ff @(posedge clock) begin
    if (reset || ctl.clear) begin
      score <= '0;
      lives <= LIVES_INIT;
    end else begin
      if (ctl.inc && score != SCORE_MAX) score <= score + 1'b1;
      if (ctl.dec && lives != '0)        lives <= lives - 1'b1;
    end
  end

endmodule

// File: rtl/asteroid_game_sequencer.sv
// Per-frame round controller: asteroid move, rocket move, collision check,
// then respawn or game over. Define MULTI_LIFE_EN for multi-life play.
module asteroid_game_sequencer
  import asteroid_game_sequencer_pkg::*;
#(
  parameter int SCORE_W   = SCORE_W_DEF,
  parameter int NUM_LIVES = NUM_LIVES_DEF,
  parameter int LIVES_W   = LIVES_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               frame_tick,
  output logic               ast_move_go,
  input  logic               ast_move_done,
  output logic               rocket_move_go,
  input  logic               rocket_move_done,
  input  logic               hit,
  input  logic               ground_hit,
  output logic               respawn_go,
  input  logic               respawn_done,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               playing,
  output logic               gameover
);

  state_e   state, state_n;
  logic     start_q, start_rise;
  cnt_ctl_t ctl;

  assign start_rise = start & ~start_q;

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      start_q        <= 1'b0;
      ast_move_go    <= 1'b0;
      rocket_move_go <= 1'b0;
      respawn_go     <= 1'b0;
      playing        <= 1'b0;
      gameover       <= 1'b0;
    end else begin
      state          <= state_n;
      start_q        <= start;
      ast_move_go    <= (state_n == S_MOVE_AST);
      rocket_move_go <= (state_n == S_MOVE_ROCKET);
      respawn_go     <= (state_n == S_RESPAWN) && (state != S_RESPAWN);
      playing        <= !(state_n inside {S_IDLE, S_GAMEOVER});
      gameover       <= (state_n == S_GAMEOVER);
    end
  end

  always_comb begin
    state_n = state;
    ctl     = '0;
    case (state)
      S_IDLE, S_GAMEOVER:
        if (start_rise) begin
          state_n   = S_WAIT_FRAME;
          ctl.clear = 1'b1;
        end
      S_WAIT_FRAME:  if (frame_tick) state_n = S_MOVE_AST;
      S_MOVE_AST:    state_n = S_WAIT_AST;
      S_WAIT_AST:    if (ast_move_done) state_n = S_MOVE_ROCKET;
      S_MOVE_ROCKET: state_n = S_WAIT_ROCKET;
      S_WAIT_ROCKET: if (rocket_move_done) state_n = S_CHECK;
      S_CHECK: begin
        if (hit) begin
          ctl.inc = 1'b1;
          state_n = S_RESPAWN;
        end else if (ground_hit) begin
`ifdef MULTI_LIFE_EN
          ctl.dec = 1'b1;
          state_n = (lives == LIVES_W'(1)) ? S_GAMEOVER : S_RESPAWN;
`else
          state_n = S_GAMEOVER;
`endif
        end else begin
          state_n = S_WAIT_FRAME;
        end
      end
      // done is only honoured after the go pulse, matching the mover handshake
      S_RESPAWN:     if (respawn_done && !respawn_go) state_n = S_WAIT_FRAME;
      default:       state_n = S_IDLE;
    endcase
  end

  asteroid_game_sequencer_score_lives_counter #(
    .SCORE_W   (SCORE_W),
    .NUM_LIVES (NUM_LIVES),
    .LIVES_W   (LIVES_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .ctl   (ctl),
    .score (score),
    .lives (lives)
  );

endmodule

// File: tb/tb_asteroid_game_sequencer.sv
// Directed bench for asteroid_game_sequencer with a 2-bit score so that
// saturation is reachable; follows MULTI_LIFE_EN if defined.
module tb_asteroid_game_sequencer;

  localparam int SW = 2;
  localparam int NL = 3;
  localparam int LW = 2;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0, frame_tick = 1'b0;
  logic ast_move_done = 1'b0, rocket_move_done = 1'b0, respawn_done = 1'b0;
  logic hit = 1'b0, ground_hit = 1'b0;
  logic ast_move_go, rocket_move_go, respawn_go, playing, gameover;
  logic [SW-1:0] score;
  logic [LW-1:0] lives;

  int nchk = 0, nfail = 0, ast_cnt = 0;
  int exp_score = 0, exp_lives = NL;
  bit exp_over = 1'b0;

  asteroid_game_sequencer #(.SCORE_W(SW), .NUM_LIVES(NL), .LIVES_W(LW)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .frame_tick       (frame_tick),
    .ast_move_go      (ast_move_go),
    .ast_move_done    (ast_move_done),
    .rocket_move_go   (rocket_move_go),
    .rocket_move_done (rocket_move_done),
    .hit              (hit),
    .ground_hit       (ground_hit),
    .respawn_go       (respawn_go),
    .respawn_done     (respawn_done),
    .score            (score),
    .lives            (lives),
    .playing          (playing),
    .gameover         (gameover)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (ast_move_go === 1'b1) ast_cnt <= ast_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  // One full frame; h/g are the collision flags presented in S_CHECK,
  // ftw pulses frame_tick while the asteroid mover is busy.
  task automatic frame(input bit h, input bit g, input bit ftw);
    int n0;
    bit resp;
    n0 = ast_cnt;
    resp = 1'b0;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("ast_go_on", ast_move_go, 1);
    chk("rkt_go_early", rocket_move_go, 0);
    ast_move_done = 1'b1; step(); ast_move_done = 1'b0;
    chk("ast_go_off", ast_move_go, 0);
    if (ftw) frame_tick = 1'b1;
    step(); frame_tick = 1'b0;
    chk("ast_done_in_go_ignored", rocket_move_go, 0);
    ast_move_done = 1'b1; step(); ast_move_done = 1'b0;
    chk("rkt_go_on", rocket_move_go, 1);
    step();
    chk("rkt_go_off", rocket_move_go, 0);
    rocket_move_done = 1'b1; hit = h; ground_hit = g;
    step(); rocket_move_done = 1'b0;
    step(); hit = 1'b0; ground_hit = 1'b0;
    if (h) begin
      if (exp_score < (1 << SW) - 1) exp_score++;
      resp = 1'b1;
    end else if (g) begin
`ifdef MULTI_LIFE_EN
      if (exp_lives == 1) begin
        exp_lives = 0;
        exp_over  = 1'b1;
      end else begin
        exp_lives--;
        resp = 1'b1;
      end
`else
      exp_over = 1'b1;
`endif
    end
    chk("score", score, exp_score);
    chk("lives", lives, exp_lives);
    chk("gameover", gameover, exp_over);
    chk("playing", playing, !exp_over);
    chk("respawn_go", respawn_go, resp);
    if (resp) begin
      step();
      chk("respawn_go_off", respawn_go, 0);
      respawn_done = 1'b1; step(); respawn_done = 1'b0;
    end
    chk("ast_pulses", ast_cnt - n0, 1);
  endtask

  task automatic new_game_exp();
    exp_score = 0;
    exp_lives = NL;
    exp_over  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    step(); step();
    chk("rst_score", score, 0);
    chk("rst_lives", lives, NL);
    chk("rst_gameover", gameover, 0);
    chk("rst_playing", playing, 0);
    chk("rst_ast_go", ast_move_go, 0);
    chk("rst_respawn_go", respawn_go, 0);

    reset = 1'b0;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("idle_ftick_ast_go", ast_move_go, 0);
    chk("idle_ftick_playing", playing, 0);

    start = 1'b1; step(); start = 1'b0;
    chk("start_playing", playing, 1);
    step();
    chk("wait_frame_no_go", ast_move_go, 0);

    frame(0, 0, 1);
    frame(1, 0, 0);
    frame(1, 1, 0);
    frame(1, 0, 0);
    frame(1, 0, 0);

    for (int i = 0; i < NL && !exp_over; i++) frame(0, 1, 0);
    step(); step();
    chk("over_hold_gameover", gameover, 1);
    chk("over_hold_score", score, 3);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("over_ftick_ast_go", ast_move_go, 0);

    start = 1'b1; step();
    new_game_exp();
    chk("restart_gameover", gameover, 0);
    chk("restart_score", score, 0);
    chk("restart_lives", lives, NL);
    chk("restart_playing", playing, 1);

    // start stays high: the next game over must not auto-restart
    frame(1, 0, 0);
    for (int i = 0; i < NL && !exp_over; i++) frame(0, 1, 0);
    step(); step();
    chk("held_start_no_restart", gameover, 1);
    start = 1'b0; step();
    start = 1'b1; step(); start = 1'b0;
    new_game_exp();
    chk("rearm_playing", playing, 1);
    chk("rearm_score", score, 0);

    // reset while waiting on the rocket mover
    frame(1, 0, 0);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step();
    ast_move_done = 1'b1; step(); ast_move_done = 1'b0;
    step();
    chk("pre_rst_rkt_go", rocket_move_go, 0);
    chk("pre_rst_score", score, 1);
    reset = 1'b1; start = 1'b1; step();
    chk("midrst_playing", playing, 0);
    chk("midrst_score", score, 0);
    chk("midrst_gameover", gameover, 0);
    chk("midrst_rkt_go", rocket_move_go, 0);
    chk("midrst_respawn_go", respawn_go, 0);
    chk("midrst_lives", lives, NL);
    reset = 1'b0; start = 1'b0; step();
    chk("post_rst_idle", playing, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/asteroid_game_sequencer.md
Name: asteroid_game_sequencer

Overview:
- Top-level round controller for the asteroid defense game.
- Once per frame it sequences the asteroid mover, then the rocket mover, then one collision evaluation.
- On a hit it updates the score and respawns the asteroid; on a ground impact it ends the game.
- Sits between the VGA frame-tick generator and the mover/collision datapaths; drives score and gameover to the display logic.

Parameters:
- SCORE_W, 8, width of the score counter (saturates at 2^SCORE_W-1).
- NUM_LIVES, 3, starting lives (used only when MULTI_LIFE_EN is defined).
- LIVES_W, 2, width of the lives counter; must hold NUM_LIVES.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; returns the block to idle.
- start  in  1  level; begins a game from S_IDLE or S_GAMEOVER.
- frame_tick  in  1  one-cycle pulse per video frame.
- ast_move_go  out  1  one-cycle pulse: asteroid mover step.
- ast_move_done  in  1  asteroid mover finished.
- rocket_move_go  out  1  one-cycle pulse: rocket mover step.
- rocket_move_done  in  1  rocket mover finished.
- hit  in  1  rocket/asteroid collision flag, valid in S_CHECK.
- ground_hit  in  1  asteroid/ground collision flag, valid in S_CHECK.
- respawn_go  out  1  one-cycle pulse: reposition the asteroid.
- respawn_done  in  1  respawn finished.
- score  out  SCORE_W  current score.
- lives  out  LIVES_W  remaining lives; constant NUM_LIVES when the feature is out.
- playing  out  1  high in every state except S_IDLE and S_GAMEOVER.
- gameover  out  1  registered; high only in S_GAMEOVER.

Behaviour:
- Reset (synchronous, checked before all other logic): state=S_IDLE; all go pulses 0; score=0; gameover=0; playing=0; lives=NUM_LIVES. Reset mid-sequence aborts immediately; no pulse is issued in the reset cycle.
- S_IDLE: on start, go to S_WAIT_FRAME; clear score and reload lives.
- S_WAIT_FRAME: on frame_tick, go to S_MOVE_AST.
- S_MOVE_AST: ast_move_go=1 for exactly this one cycle; go to S_WAIT_AST.
- S_WAIT_AST: on ast_move_done, go to S_MOVE_ROCKET. A done arriving in the go cycle itself is ignored; done counts from the cycle after go.
- S_MOVE_ROCKET / S_WAIT_ROCKET: same protocol with rocket_move_go/rocket_move_done; exits to S_CHECK.
- S_CHECK (single cycle, samples hit and ground_hit):
  - hit=1 → score+1, saturating at max → S_RESPAWN. hit has priority when hit and ground_hit are both 1.
  - ground_hit=1 only → S_GAMEOVER.
  - neither → S_WAIT_FRAME.
- S_RESPAWN: respawn_go pulses on entry; wait for respawn_done, then go to S_WAIT_FRAME.
- S_GAMEOVER: gameover=1; score is held. On start, go to S_WAIT_FRAME with score cleared and lives reloaded. start must deassert between games; enforce with an internal rising-edge detect on start.
- frame_tick outside S_WAIT_FRAME is dropped, not queued. Latency from frame_tick to ast_move_go is 1 cycle.
- Outputs are registered; go pulses are derived from the registered state and are never combinational from inputs.
- start asserted together with reset: reset wins.

Optional Feature:
- Macro: MULTI_LIFE_EN.
- Defined: ground_hit in S_CHECK decrements lives. If lives was 1, go to S_GAMEOVER with lives=0. Otherwise go to S_RESPAWN with no score change. hit still has priority over ground_hit.
- Undefined: first ground_hit ends the game; lives is tied to NUM_LIVES.

Decomposition:
- Shared package/header (game_defs.vh) holds:
  - state encodings (4-bit localparams S_IDLE…S_GAMEOVER);
  - SCORE_W and NUM_LIVES defaults.
- One natural sub-module: score_lives_counter. Holds the saturating score, the lives counter and the clear/load control; the FSM drives its inc/dec/clear strobes.

Test Plan:
- Reset, start=1, one frame_tick, movers answer done after 2 cycles, hit=0, ground_hit=0 → go pulses each exactly 1 cycle; returns to S_WAIT_FRAME; score=0.
- Frame with hit=1 → score 0→1, respawn_go pulses once; after respawn_done, the next frame_tick sequences normally. With SCORE_W=2, force 4 hits → score stays 3.
- hit=1 and ground_hit=1 in the same S_CHECK → score+1, no gameover.
- ground_hit=1, feature out → gameover=1, playing=0, score held. Toggle start → score=0, gameover=0.
- Feature in, NUM_LIVES=3, three ground hits → lives 3→2→1→0, gameover on the third hit only.
- frame_tick pulsed while in S_WAIT_AST → ignored (no extra ast_move_go). Reset asserted in S_WAIT_ROCKET → next cycle S_IDLE, all outputs at reset values.
